// File: rtl/hack_cpu_pkg.sv
// Hack ISA widths and instruction field positions shared by the CPU core and its ALU.
package hack_cpu_pkg;

  localparam int ISA_DATA_W = 16;
  localparam int ISA_ADDR_W = 15;

  localparam int CI       = 15;
  localparam int ASEL     = 12;
  localparam int CTRL_HI  = 11;
  localparam int CTRL_LO  = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int JMP_LT   = 2;
  localparam int JMP_EQ   = 1;
  localparam int JMP_GT   = 0;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

endpackage

// File: rtl/hack_cpu_alu.sv
// Hack ALU: purely combinational, zero latency, no flow control.
module hack_cpu_alu
  import hack_cpu_pkg::*;
#(
  parameter int DATA_W = ISA_DATA_W
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  alu_ctrl_t         ctrl,
  output logic [DATA_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [DATA_W-1:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z   = ctrl.zx ? '0 : x;
    x_n   = ctrl.nx ? ~x_z : x_z;
    y_z   = ctrl.zy ? '0 : y;
    y_n   = ctrl.ny ? ~y_z : y_z;
    f_out = ctrl.f ? (x_n + y_n) : (x_n & y_n);
    out   = ctrl.no ? ~f_out : f_out;
  end

  assign zr = (out == '0);
  assign ng = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: decodes A/C instructions, holds A/D/PC, drives the data-memory port.
// One instruction per cycle; memory outputs are combinational, no stalls or backpressure.
module hack_cpu
  import hack_cpu_pkg::*;
#(
  parameter int DATA_W = ISA_DATA_W,
  parameter int ADDR_W = ISA_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inM,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  logic [DATA_W-1:0] a_reg, d_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] alu_y, alu_out;
  logic              alu_zr, alu_ng;
  logic              is_c, jump;
  alu_ctrl_t         ctrl;

  assign is_c  = instruction[CI];
  assign ctrl  = alu_ctrl_t'(instruction[CTRL_HI:CTRL_LO]);
  assign alu_y = instruction[ASEL] ? inM : a_reg;

  hack_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .x    (d_reg),
    .y    (alu_y),
    .ctrl (ctrl),
    .out  (alu_out),
    .zr   (alu_zr),
    .ng   (alu_ng)
  );

  assign jump = is_c & ((instruction[JMP_LT] & alu_ng) |
                        (instruction[JMP_EQ] & alu_zr) |
                        (instruction[JMP_GT] & ~alu_ng & ~alu_zr));

  // Address and jump target come from A before this instruction updates it.
  assign outM     = alu_out;
  assign writeM   = is_c & instruction[DEST_M] & ~reset;
  assign addressM = a_reg[ADDR_W-1:0];
  assign pc       = pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      d_reg  <= '0;
      pc_reg <= '0;
    end else begin
      if (!is_c)
        a_reg <= instruction;
      else if (instruction[DEST_A])
        a_reg <= alu_out;
      if (is_c && instruction[DEST_D])
        d_reg <= alu_out;
      pc_reg <= jump ? a_reg[ADDR_W-1:0] : pc_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed-vector bench for hack_cpu: drives one instruction per cycle, checks outputs.
module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inM;
  logic [15:0] instruction;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int errors = 0;
  int checks = 0;

  hack_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .inM         (inM),
    .instruction (instruction),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp_v);
    end
  endtask

  // Apply an instruction shortly after a posedge; combinational outputs settle by return.
  task automatic drive(input logic [15:0] inst, input logic [15:0] m);
    instruction = inst;
    inM         = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    instruction = 16'hEA87;
    inM = 16'h0000;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin
      drive(16'hEA87, 16'h0000);
      chk("rst_writeM", {15'b0, writeM}, 16'h0000);
      tick();
      chk("rst_pc", {1'b0, pc}, 16'h0000);
      chk("rst_addressM", {1'b0, addressM}, 16'h0000);
    end
    reset = 1'b0;

    // @5; D=A; M=D
    drive(16'h0005, 16'h0000);
    chk("a_instr_writeM", {15'b0, writeM}, 16'h0000);
    tick();
    chk("pc_1", {1'b0, pc}, 16'h0001);
    drive(16'hEC10, 16'h0000);
    tick();
    chk("pc_2", {1'b0, pc}, 16'h0002);
    drive(16'hE308, 16'h0000);
    chk("md_outM", outM, 16'h0005);
    chk("md_writeM", {15'b0, writeM}, 16'h0001);
    chk("md_addressM", {1'b0, addressM}, 16'h0005);
    tick();
    chk("pc_3", {1'b0, pc}, 16'h0003);

    // @7; D=M with inM=0x1234; M=D
    drive(16'h0007, 16'h0000);
    tick();
    drive(16'hFC10, 16'h1234);
    tick();
    drive(16'hE308, 16'h0000);
    chk("dm_outM", outM, 16'h1234);
    chk("dm_addressM", {1'b0, addressM}, 16'h0007);
    tick();

    // @100; 0;JMP
    drive(16'h0064, 16'h0000);
    tick();
    drive(16'hEA87, 16'h0000);
    tick();
    chk("jmp_pc", {1'b0, pc}, 16'd100);
    // D=0; D;JEQ taken back to 100
    drive(16'hEA90, 16'h0000);
    tick();
    chk("d0_pc", {1'b0, pc}, 16'd101);
    drive(16'hE302, 16'h0000);
    chk("jeq_no_write", {15'b0, writeM}, 16'h0000);
    tick();
    chk("jeq_taken_pc", {1'b0, pc}, 16'd100);
    // @3; D=A; D;JEQ not taken
    drive(16'h0003, 16'h0000);
    tick();
    drive(16'hEC10, 16'h0000);
    tick();
    drive(16'hE302, 16'h0000);
    tick();
    chk("jeq_not_taken_pc", {1'b0, pc}, 16'd103);

    // @50; A=0;JMP -> jump to old A, A becomes 0
    drive(16'h0032, 16'h0000);
    tick();
    drive(16'hEAA7, 16'h0000);
    chk("ajmp_addr_old", {1'b0, addressM}, 16'd50);
    tick();
    chk("ajmp_pc_old_a", {1'b0, pc}, 16'd50);
    chk("ajmp_a_new", {1'b0, addressM}, 16'h0000);

    // @9; AM=M+1 with inM=0x7FFF
    drive(16'h0009, 16'h0000);
    tick();
    drive(16'hFDE8, 16'h7FFF);
    chk("amp1_outM", outM, 16'h8000);
    chk("amp1_writeM", {15'b0, writeM}, 16'h0001);
    chk("amp1_addressM", {1'b0, addressM}, 16'h0009);
    tick();
    drive(16'h0000, 16'h0000);
    chk("amp1_addr_after", {1'b0, addressM}, 16'h0000);

    // Walk the PC up to the top of its range, then wrap.
    begin
      int budget = 40000;
      while (pc != 15'h7FFF && budget > 0) begin
        drive(16'h0000, 16'h0000);
        tick();
        budget--;
      end
      chk("pc_reach_top", {1'b0, pc}, 16'h7FFF);
    end
    drive(16'h0000, 16'h0000);
    tick();
    chk("pc_wrap", {1'b0, pc}, 16'h0000);

    // Mid-program reset must suppress a pending memory write.
    drive(16'h0014, 16'h0000);
    tick();
    drive(16'hE308, 16'h0000);
    chk("pre_rst_writeM", {15'b0, writeM}, 16'h0001);
    reset = 1'b1;
    #1;
    chk("mid_rst_writeM", {15'b0, writeM}, 16'h0000);
    tick();
    chk("mid_rst_pc", {1'b0, pc}, 16'h0000);
    chk("mid_rst_addressM", {1'b0, addressM}, 16'h0000);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
